// File: rtl/rtc_bus_responder.sv
// Purpose : PicoBlaze I/O slave that turns port writes into timed RTC multiplexed-bus write/read cycles.
// Latency : a cycle starts the clock after the command; 4*T_PH+1 cycles until IDLE; in_portRTC is registered (1 cycle).
// Backpress: no stall. Start commands issued while busy are dropped and flagged in err; a status read clears err.
//
// Ports:
//   clk, reset            system clock, asynchronous active-low reset
//   dir, out_port         processor port_id and write data
//   writestrobe           processor write strobe, 1-cycle pulse
//   read_strobe           processor read strobe, 1-cycle pulse
//   actRTC                chip select for this block
//   in_portRTC            registered read data: rdata or {6'b0, err, busy}
//   busy                  RTC bus cycle in progress
//   ad_out, ad_oe, ad_in  RTC AD bus: drive value, drive enable, sampled pins
//   ad_sel                RTC A/D line: 1 = address phase, 0 = data phase
//   cs_n, wr_n, rd_n      RTC chip select and strobes, active-low
module rtc_bus_responder #(
    parameter int unsigned T_PH     = 4,
    parameter logic [7:0]  P_ADDR   = 8'h00,
    parameter logic [7:0]  P_WDATA  = 8'h01,
    parameter logic [7:0]  P_RCMD   = 8'h02,
    parameter logic [7:0]  P_RDATA  = 8'h03,
    parameter logic [7:0]  P_STATUS = 8'h04
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dir,
    input  logic [7:0] out_port,
    input  logic       writestrobe,
    input  logic       read_strobe,
    input  logic       actRTC,
    output logic [7:0] in_portRTC,
    output logic       busy,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    output logic       ad_sel,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        A_LOW  = 3'd1,
        A_HIGH = 3'd2,
        D_LOW  = 3'd3,
        D_HIGH = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [7:0] PH_LAST = 8'(T_PH - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt;
    logic [7:0] addr;
    logic [7:0] cyc_addr;   // address frozen for the running cycle
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       op_rd;
    logic       err;

    logic wr_acc, is_start, start, collide, err_clr, phase_end;

    assign wr_acc    = writestrobe && actRTC;
    assign is_start  = wr_acc && ((dir == P_WDATA) || (dir == P_RCMD));
    assign start     = is_start && (state == IDLE);
    assign collide   = is_start && (state != IDLE);
    assign err_clr   = read_strobe && actRTC && (dir == P_STATUS);
    assign phase_end = (cnt == 8'd0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = A_LOW;
            A_LOW:   if (phase_end) state_nxt = A_HIGH;
            A_HIGH:  if (phase_end) state_nxt = D_LOW;
            D_LOW:   if (phase_end) state_nxt = D_HIGH;
            D_HIGH:  if (phase_end) state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Phase counter reloads on every state change so each phase lasts T_PH cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 8'd0;
        end else if (state_nxt != state) begin
            cnt <= PH_LAST;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    // Command registers, read capture, error flag and processor read mux
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr       <= 8'd0;
            cyc_addr   <= 8'd0;
            wdata      <= 8'd0;
            rdata      <= 8'd0;
            op_rd      <= 1'b0;
            err        <= 1'b0;
            in_portRTC <= 8'd0;
        end else begin
            if (wr_acc && (dir == P_ADDR)) begin
                addr <= out_port;
            end
            if (start) begin
                cyc_addr <= addr;
                op_rd    <= (dir == P_RCMD);
                if (dir == P_WDATA) begin
                    wdata <= out_port;
                end
            end
            if ((state == D_LOW) && op_rd && phase_end) begin
                rdata <= ad_in;
            end
            // A new collision on the same edge as a status read keeps err set.
            if (collide) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
            // port_id leads the read capture, so this mux ignores actRTC.
            if (dir == P_RDATA) begin
                in_portRTC <= rdata;
            end else if (dir == P_STATUS) begin
                in_portRTC <= {6'b0, err, busy};
            end else begin
                in_portRTC <= 8'd0;
            end
        end
    end

    // Outputs decode straight from the async-reset state so pins go inactive at once on reset.
    always_comb begin
        cs_n   = 1'b1;
        wr_n   = 1'b1;
        rd_n   = 1'b1;
        ad_oe  = 1'b0;
        ad_sel = 1'b1;
        ad_out = 8'd0;
        case (state)
            A_LOW: begin
                cs_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = cyc_addr;
                wr_n   = 1'b0;
            end
            A_HIGH: begin
                cs_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = cyc_addr;
            end
            D_LOW: begin
                cs_n   = 1'b0;
                ad_sel = 1'b0;
                if (op_rd) begin
                    rd_n = 1'b0;
                end else begin
                    ad_oe  = 1'b1;
                    ad_out = wdata;
                    wr_n   = 1'b0;
                end
            end
            D_HIGH: begin
                cs_n   = 1'b0;
                ad_sel = 1'b0;
                if (!op_rd) begin
                    ad_oe  = 1'b1;
                    ad_out = wdata;
                end
            end
            default: begin
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Purpose : directed bench for rtc_bus_responder at T_PH=4 and T_PH=1 (two instances, shared processor inputs).
// Latency : inputs driven on the falling edge, outputs sampled on the falling edge after each rising edge.
// Backpress: none; every wait on the DUT is bounded by a cycle budget.
module tb_rtc_bus_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] dir;
    logic [7:0] out_port;
    logic       writestrobe;
    logic       read_strobe;
    logic       actRTC;

    logic [7:0] in_port4, ad_out4, ad_in4;
    logic       busy4, ad_oe4, ad_sel4, cs_n4, wr_n4, rd_n4;
    logic [7:0] in_port1, ad_out1, ad_in1;
    logic       busy1, ad_oe1, ad_sel1, cs_n1, wr_n1, rd_n1;

    int n_tests = 0;
    int n_fail  = 0;
    int ovl_cnt = 0;
    int oe_bad  = 0;

    always #5 clk = ~clk;

    // RTC chip models: drive data only while the read strobe is low.
    assign ad_in4 = rd_n4 ? 8'hFF : 8'h37;
    assign ad_in1 = rd_n1 ? 8'hFF : 8'h5C;

    rtc_bus_responder #(.T_PH(4)) dut4 (
        .clk(clk), .reset(reset), .dir(dir), .out_port(out_port),
        .writestrobe(writestrobe), .read_strobe(read_strobe), .actRTC(actRTC),
        .in_portRTC(in_port4), .busy(busy4), .ad_out(ad_out4), .ad_oe(ad_oe4),
        .ad_in(ad_in4), .ad_sel(ad_sel4), .cs_n(cs_n4), .wr_n(wr_n4), .rd_n(rd_n4)
    );

    rtc_bus_responder #(.T_PH(1)) dut1 (
        .clk(clk), .reset(reset), .dir(dir), .out_port(out_port),
        .writestrobe(writestrobe), .read_strobe(read_strobe), .actRTC(actRTC),
        .in_portRTC(in_port1), .busy(busy1), .ad_out(ad_out1), .ad_oe(ad_oe1),
        .ad_in(ad_in1), .ad_sel(ad_sel1), .cs_n(cs_n1), .wr_n(wr_n1), .rd_n(rd_n1)
    );

    // Pin-protocol watchers across the whole run.
    always @(negedge clk) begin
        if (reset) begin
            if (!wr_n4 && !rd_n4) ovl_cnt++;
            if (!wr_n1 && !rd_n1) ovl_cnt++;
            if (!rd_n4 && ad_oe4) oe_bad++;
            if (!rd_n1 && ad_oe1) oe_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; the command is taken on the next rising edge and
    // the task returns on the falling edge after it.
    task automatic bus_write(input logic [7:0] d, input logic [7:0] data);
        dir         = d;
        out_port    = data;
        writestrobe = 1'b1;
        actRTC      = 1'b1;
        @(negedge clk);
        writestrobe = 1'b0;
        actRTC      = 1'b0;
    endtask

    // Counts busy samples until the selected instance is idle, capped at 100.
    task automatic wait_idle(input bit use_fast, output int n);
        n = 0;
        while ((use_fast ? busy1 : busy4) && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    int cs_cnt, a_cnt, d_cnt, busy_cnt, first_idle, rd_cnt, rd_oe, bad_cnt, n;

    initial begin
        reset       = 1'b0;
        dir         = 8'h00;
        out_port    = 8'h00;
        writestrobe = 1'b0;
        read_strobe = 1'b0;
        actRTC      = 1'b0;

        // Reset
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_pins4", {cs_n4, wr_n4, rd_n4, ad_oe4, ad_sel4, busy4}, 32'b111010);
        check("rst_inport4", in_port4, 8'h00);
        check("rst_pins1", {cs_n1, wr_n1, rd_n1, ad_oe1, ad_sel1, busy1}, 32'b111010);

        // Write cycle at T_PH=4
        bus_write(8'h00, 8'h21);
        bus_write(8'h01, 8'h5A);
        cs_cnt = 0; a_cnt = 0; d_cnt = 0; busy_cnt = 0; first_idle = -1;
        for (int i = 0; i < 20; i++) begin
            if (!cs_n4) cs_cnt++;
            if (!wr_n4 && ad_sel4 && ad_oe4 && ad_out4 == 8'h21) a_cnt++;
            if (!wr_n4 && !ad_sel4 && ad_oe4 && ad_out4 == 8'h5A) d_cnt++;
            if (busy4) busy_cnt++;
            if (!busy4 && first_idle < 0) first_idle = i;
            @(negedge clk);
        end
        check("wr_cs_low", cs_cnt, 16);
        check("wr_addr_phase", a_cnt, 4);
        check("wr_data_phase", d_cnt, 4);
        check("wr_busy_cycles", busy_cnt, 17);
        check("wr_idle_at", first_idle, 17);

        // Read cycle at T_PH=4
        bus_write(8'h02, 8'h00);
        rd_cnt = 0; rd_oe = 0;
        for (int i = 0; i < 20; i++) begin
            if (!rd_n4) rd_cnt++;
            if (!rd_n4 && ad_oe4) rd_oe++;
            @(negedge clk);
        end
        check("rd_strobe_len", rd_cnt, 4);
        check("rd_oe_off", rd_oe, 0);
        dir = 8'h03;
        @(negedge clk);
        check("rd_data", in_port4, 8'h37);

        // Busy collision: the second data write must be dropped
        bus_write(8'h01, 8'hAA);
        bus_write(8'h01, 8'h77);
        dir = 8'h04;
        @(negedge clk);
        check("coll_status", in_port4, 8'h03);
        read_strobe = 1'b1;
        actRTC      = 1'b1;
        @(negedge clk);
        read_strobe = 1'b0;
        actRTC      = 1'b0;
        d_cnt = 0; bad_cnt = 0; n = 0;
        while (busy4 && n < 60) begin
            if (!wr_n4 && !ad_sel4 && ad_out4 == 8'hAA) d_cnt++;
            if (ad_out4 == 8'h77) bad_cnt++;
            n++;
            @(negedge clk);
        end
        check("coll_data_kept", d_cnt, 4);
        check("coll_no_new", bad_cnt, 0);
        @(negedge clk);
        check("coll_status_clr", in_port4, 8'h00);

        // Reset in the middle of the data phase of a write
        bus_write(8'h01, 8'h3C);
        repeat (9) @(negedge clk);
        check("mid_wr_low", wr_n4, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_pins", {cs_n4, wr_n4, rd_n4, ad_oe4, busy4}, 32'b11100);
        @(negedge clk);
        reset = 1'b1;
        bad_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!cs_n4 || !wr_n4 || !rd_n4) bad_cnt++;
            @(negedge clk);
        end
        check("mid_no_resume", bad_cnt, 0);

        // T_PH=1: read immediately followed by write
        bus_write(8'h02, 8'h00);
        wait_idle(1'b1, n);
        check("fast_rd_len", n, 5);
        bus_write(8'h01, 8'h99);
        wait_idle(1'b1, n);
        check("fast_wr_len", n, 5);
        dir = 8'h03;
        @(negedge clk);
        check("fast_rd_data", in_port1, 8'h5C);

        check("no_wr_rd_overlap", ovl_cnt, 0);
        check("no_oe_during_rd", oe_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
